lane_mux_rr: RTL

LANE_MUX_RR -- requirements
Module: lane_mux_rr

---
 rtl/lane_mux_rr.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/lane_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : lane_mux_rr
// Description : Multi-lane input buffer with a per-lane FIFO and a single
//               registered output. Lanes are arbitrated round-robin by
//               default, or by fixed priority (lowest lane wins) when the
//               macro LANE_MUX_STRICT_PRIO_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_mux_rr #(
    parameter int LANES = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                                     clk,
    input  wire logic                                     reset,
    input  wire logic [LANES-1:0]                         valid_in,
    input  wire logic [LANES*WIDTH-1:0]                   data_in,
    output logic      [LANES-1:0]                         full_out,
    output logic      [LANES-1:0]                         overflow,
    input  wire logic                                     ready_in,
    output logic                                          valid_out,
    output logic      [WIDTH-1:0]                         data_out,
    output logic      [((LANES > 1) ? $clog2(LANES) : 1)-1:0] lane_out
);

    localparam int c_LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_CNT_ONE  = (c_AW+1)'(1);
    localparam logic [c_AW:0] c_CNT_FULL = (c_AW+1)'(DEPTH);

    logic [LANES-1:0]  w_push;
    logic [LANES-1:0]  w_pop;
    logic [LANES-1:0]  w_nempty;
    logic [WIDTH-1:0]  w_head [LANES];
    logic              w_load;
    logic              w_any;
    logic              w_found;
    logic [c_LW-1:0]   w_grant;
    logic [c_LW-1:0]   w_cand;

    logic              r_valid;
    logic [WIDTH-1:0]  r_data;
    logic [c_LW-1:0]   r_lane;

    // The output register is free when empty or when its word is being taken.
    assign w_load = ~r_valid | ready_in;
    assign w_any  = |w_nempty;

    // ------------------------------------------------------------------------
    // Per-lane FIFOs
    // ------------------------------------------------------------------------
    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [c_AW-1:0]  r_wptr;
            logic [c_AW-1:0]  r_rptr;
            logic [c_AW:0]    r_count;
            logic [c_AW:0]    w_count_nxt;
            logic             r_full;
            logic             r_ovf;

            // Full is based on pre-edge occupancy, so a write racing a pop
            // on a full FIFO is still dropped.
            assign w_push[g]   = valid_in[g] & ~r_full;
            assign w_pop[g]    = w_load & w_any & (w_grant == c_LW'(g));
            assign w_nempty[g] = (r_count != '0);
            assign w_head[g]   = r_mem[r_rptr];
            assign full_out[g] = r_full;
            assign overflow[g] = r_ovf;

            // Next occupancy; simultaneous push and pop leaves it unchanged.
            always_comb begin
                w_count_nxt = r_count;
                if (w_push[g] && !w_pop[g]) begin
                    w_count_nxt = r_count + c_CNT_ONE;
                end else if (!w_push[g] && w_pop[g]) begin
                    w_count_nxt = r_count - c_CNT_ONE;
                end
            end

            // Pointer, occupancy, full and sticky overflow state.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                    r_full  <= 1'b0;
                    r_ovf   <= 1'b0;
                end else begin
                    if (w_push[g]) begin
                        r_wptr <= r_wptr + c_AW'(1);
                    end
                    if (w_pop[g]) begin
                        r_rptr <= r_rptr + c_AW'(1);
                    end
                    r_count <= w_count_nxt;
                    r_full  <= (w_count_nxt == c_CNT_FULL);
                    if (valid_in[g] && r_full) begin
                        r_ovf <= 1'b1;
                    end
                end
            end

            // Storage array; no reset needed since pointers define contents.
            always_ff @(posedge clk) begin
                if (!reset && w_push[g]) begin
                    r_mem[r_wptr] <= data_in[g*WIDTH +: WIDTH];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
`ifdef LANE_MUX_STRICT_PRIO_EN
    // Fixed priority: lowest-numbered non-empty lane wins.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < LANES; k++) begin
            w_cand = c_LW'(k);
            if (!w_found && w_nempty[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end
`else
    logic [c_LW-1:0] r_last;

    // Round-robin: first non-empty lane searching upward from last grant + 1.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= LANES; k++) begin
            w_cand = c_LW'((int'(r_last) + k) % LANES);
            if (!w_found && w_nempty[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    // Last grant moves only when a word is actually popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= c_LW'(LANES - 1);
        end else if (w_load && w_any) begin
            r_last <= w_grant;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------------
    // Load the granted head word whenever the output slot is free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_lane  <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_data  <= w_head[w_grant];
                r_lane  <= w_grant;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid_out = r_valid;
    assign data_out  = r_data;
    assign lane_out  = r_lane;

endmodule
`default_nettype wire
